button_event_unit: RTL and testbench

Memory-mapped input stage for the four push buttons (BTNU, BTNL, BTND, BTNR). It sits between the board pins and the processor's data-memory read mux, next to the switch port at 4096 and the LED port at 4097. Each button is synchronised and debounced. Each press sets a sticky pending bit. Software reads the bits at `ADDR_BTN` and clears them by storing a write-1-to-clear mask to the same address.

---
 rtl/button_event_unit.sv | 117 +++++++++++
 tb/tb_button_event_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_unit.sv
// Memory-mapped push-button port: 2-flop sync, per-button debounce, press events, W1C pending bits.
// Optional auto-repeat of held buttons when BTN_AUTOREPEAT_EN is defined.
module button_event_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 800000,
  parameter logic [31:0] ADDR_BTN        = 32'd4098,
  parameter int unsigned REPEAT_CYCLES   = 16000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  btn_in,
  input  logic [31:0] mem_addr,
  input  logic        mem_wren,
  input  logic [31:0] mem_data,
  output logic        btn_sel,
  output logic [31:0] q_btn,
  output logic [3:0]  btn_level,
  output logic [3:0]  btn_event
);

  localparam logic [23:0] DbMax = 24'(DEBOUNCE_CYCLES - 1);

  logic [3:0]  sync1_q, sync2_q;
  logic [3:0]  level_q, level_d, level_dly_q;
  logic [3:0]  pending_q, pending_d, event_q;
  logic [3:0]  rise, repeat_hit, clr;
  logic [23:0] db_cnt_q [4];
  logic [23:0] db_cnt_d [4];

  assign btn_sel = (mem_addr == ADDR_BTN);
  assign clr     = (mem_wren && btn_sel) ? mem_data[3:0] : 4'b0;
  assign rise    = level_q & ~level_dly_q;

  // Counter runs only while the synchronised input disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DbMax) begin
          level_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 24'd1;
        end
      end
    end
  end

  // Set has priority over a same-cycle clear so no press is lost.
  assign pending_d = (pending_q & ~clr) | rise | repeat_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      pending_q   <= '0;
      event_q     <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= btn_in;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      pending_q   <= pending_d;
      event_q     <= rise | repeat_hit;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [23:0] RepMax = 24'(REPEAT_CYCLES - 1);

  logic [23:0] rep_cnt_q [4];

  // Repeat period is measured from the press event, then from each repeat.
  always_comb begin
    repeat_hit = '0;
    for (int i = 0; i < 4; i++) begin
      repeat_hit[i] = level_q[i] && !rise[i] && (rep_cnt_q[i] == RepMax);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        rep_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!level_q[i] || rise[i] || repeat_hit[i]) begin
          rep_cnt_q[i] <= '0;
        end else begin
          rep_cnt_q[i] <= rep_cnt_q[i] + 24'd1;
        end
      end
    end
  end
`else
  assign repeat_hit = 4'b0;

  logic unused_repeat;
  assign unused_repeat = ^REPEAT_CYCLES;
`endif

  logic unused_data;
  assign unused_data = ^mem_data[31:4];

  assign q_btn     = {24'b0, level_q, pending_q};
  assign btn_level = level_q;
  assign btn_event = event_q;

endmodule

// File: tb/tb_button_event_unit.sv
// Self-checking bench for button_event_unit: directed scenarios plus random button/bus traffic
// compared every cycle against a window-based behavioural model.
module tb_button_event_unit;

  localparam int unsigned Db      = 4;
  localparam int unsigned Rep     = 10;
  localparam logic [31:0] AddrBtn = 32'd4098;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AutoRepeat = 1'b1;
`else
  localparam bit AutoRepeat = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [3:0]  btn_in;
  logic [31:0] mem_addr;
  logic        mem_wren;
  logic [31:0] mem_data;
  logic        btn_sel;
  logic [31:0] q_btn;
  logic [3:0]  btn_level;
  logic [3:0]  btn_event;

  int vectors;
  int miscompares;

  button_event_unit #(
    .DEBOUNCE_CYCLES(Db),
    .ADDR_BTN       (AddrBtn),
    .REPEAT_CYCLES  (Rep)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_in   (btn_in),
    .mem_addr (mem_addr),
    .mem_wren (mem_wren),
    .mem_data (mem_data),
    .btn_sel  (btn_sel),
    .q_btn    (q_btn),
    .btn_level(btn_level),
    .btn_event(btn_event)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: history of raw samples; a level flips once the last Db synchronised samples all
  // disagree with it. Events follow a level rise by one cycle, repeats every Rep cycles after.
  logic [3:0] pipe [$];
  logic [3:0] m_lvl, m_lvl_prev, m_pend, m_evt;
  int         m_last [4];
  int         cyc;

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < Db + 2; i++) pipe.push_back(4'b0);
    m_lvl = '0; m_lvl_prev = '0; m_pend = '0; m_evt = '0; cyc = 0;
    for (int i = 0; i < 4; i++) m_last[i] = -1000000;
  endtask

  task automatic model_edge();
    logic [3:0] clr_m;
    logic [3:0] nl;
    bit         all_differ;
    cyc++;
    clr_m = (mem_wren && mem_addr == AddrBtn) ? mem_data[3:0] : 4'b0;
    for (int i = 0; i < 4; i++) begin
      m_evt[i] = m_lvl[i] & ~m_lvl_prev[i];
      if (AutoRepeat && !m_evt[i] && m_lvl[i] && (cyc - m_last[i] == int'(Rep))) m_evt[i] = 1'b1;
      if (m_evt[i]) m_last[i] = cyc;
    end
    m_pend = (m_pend & ~clr_m) | m_evt;
    nl = m_lvl;
    for (int i = 0; i < 4; i++) begin
      all_differ = 1'b1;
      for (int j = 1; j <= int'(Db); j++) begin
        if (pipe[pipe.size() - 1 - j][i] == m_lvl[i]) all_differ = 1'b0;
      end
      if (all_differ) nl[i] = ~m_lvl[i];
    end
    m_lvl_prev = m_lvl;
    m_lvl      = nl;
    pipe.push_back(btn_in);
    void'(pipe.pop_front());
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want)
    else begin
      miscompares++;
      $error("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  task automatic check_model();
    chk("q_btn", q_btn, {24'b0, m_lvl, m_pend});
    chk("btn_level", {28'b0, btn_level}, {28'b0, m_lvl});
    chk("btn_event", {28'b0, btn_event}, {28'b0, m_evt});
    chk("btn_sel", {31'b0, btn_sel}, {31'b0, mem_addr == AddrBtn});
  endtask

  task automatic step();
    @(posedge clock);
    if (reset) model_reset();
    else model_edge();
    #1;
    check_model();
  endtask

  task automatic store(input logic [31:0] data);
    mem_addr = AddrBtn; mem_wren = 1'b1; mem_data = data;
    step();
    mem_wren = 1'b0; mem_addr = 32'd0; mem_data = '0;
  endtask

  int ev_at [$];
  int exp_ev [$];
  int hold [4];
  int r;

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; btn_in = '0; mem_addr = '0; mem_wren = 1'b0; mem_data = '0;
    model_reset();
    repeat (3) step();
    reset = 1'b0;
    chk("reset_q_btn", q_btn, 32'h0);
    chk("reset_level", {28'b0, btn_level}, 32'h0);
    mem_addr = 32'd4098; #1;
    chk("sel_4098", {31'b0, btn_sel}, 32'h1);
    mem_addr = 32'd4096; #1;
    chk("sel_4096", {31'b0, btn_sel}, 32'h0);

    // Clean BTNR press
    btn_in = 4'b0001;
    repeat (6) step();
    chk("btnr_c6_event", {28'b0, btn_event}, 32'h0);
    step();
    chk("btnr_c7_event", {28'b0, btn_event}, 32'h1);
    chk("btnr_c7_q", q_btn, 32'h11);
    step();
    chk("btnr_c8_event", {28'b0, btn_event}, 32'h0);
    chk("btnr_c8_q", q_btn, 32'h11);
    btn_in = 4'b0000;
    repeat (8) step();
    store(32'hF);

    // BTNU bouncing every 2 cycles, then held
    for (int c = 0; c < 20; c++) begin
      btn_in = ((c / 2) % 2 == 0) ? 4'b1000 : 4'b0000;
      step();
      chk("bounce_no_event", {28'b0, btn_event}, 32'h0);
    end
    btn_in = 4'b1000;
    repeat (6) step();
    chk("bounce_c6_event", {28'b0, btn_event}, 32'h0);
    step();
    chk("bounce_c7_event", {28'b0, btn_event}, 32'h8);
    btn_in = 4'b0000;
    repeat (8) step();
    store(32'hF);

    // Write-1-to-clear and set-wins
    btn_in = 4'b0100;
    repeat (8) step();
    btn_in = 4'b0000;
    repeat (8) step();
    chk("btnl_pending", {28'b0, q_btn[3:0]}, 32'h4);
    store(32'h4);
    chk("btnl_cleared", {28'b0, q_btn[3:0]}, 32'h0);
    btn_in = 4'b0010;
    repeat (6) step();
    store(32'h6);
    chk("setwins_event", {28'b0, btn_event}, 32'h2);
    chk("setwins_pending", {28'b0, q_btn[3:0]}, 32'h2);
    btn_in = 4'b0000;
    repeat (8) step();
    store(32'hF);

    // Reset mid-debounce while BTNU is held
    btn_in = 4'b1000;
    repeat (3) step();
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_mid_q", q_btn, 32'h0);
    chk("rst_mid_level", {28'b0, btn_level}, 32'h0);
    chk("rst_mid_event", {28'b0, btn_event}, 32'h0);
    repeat (2) step();
    reset = 1'b0;
    repeat (6) step();
    chk("rst_c6_event", {28'b0, btn_event}, 32'h0);
    step();
    chk("rst_c7_event", {28'b0, btn_event}, 32'h8);
    btn_in = 4'b0000;
    repeat (8) step();
    store(32'hF);

    // BTNR held 40 cycles: auto-repeat build repeats every Rep cycles
    btn_in = 4'b0001;
    for (int c = 1; c <= 48; c++) begin
      step();
      if (btn_event[0]) ev_at.push_back(c);
      if (c == 40) btn_in = 4'b0000;
    end
    exp_ev.push_back(7);
    if (AutoRepeat) begin
      exp_ev.push_back(17); exp_ev.push_back(27); exp_ev.push_back(37);
    end
    chk("repeat_count", ev_at.size(), exp_ev.size());
    for (int k = 0; k < exp_ev.size() && k < ev_at.size(); k++) begin
      chk("repeat_cycle", ev_at[k], exp_ev[k]);
    end
    repeat (8) step();
    store(32'hF);

    // Random button activity and bus traffic
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          btn_in[i] = ~btn_in[i];
          hold[i]   = $urandom_range(1, 9);
        end else begin
          hold[i]--;
        end
      end
      r = $urandom_range(0, 7);
      mem_wren = 1'b0;
      mem_data = $urandom;
      case (r)
        0: begin mem_addr = AddrBtn; mem_wren = 1'b1; end
        1, 2: mem_addr = AddrBtn;
        3: mem_addr = 32'd4096;
        4: begin mem_addr = 32'd4097; mem_wren = 1'b1; end
        5: begin mem_addr = $urandom; mem_wren = $urandom_range(0, 1) == 1; end
        default: mem_addr = 32'd0;
      endcase
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
